// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default operand width.
package serial_add_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two 4:1 muxes selected by {x,y}.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic c
);

  logic [3:0] s_sel;
  logic [3:0] c_sel;

  // Entry index is {x,y}: 00 -> bit 0, 11 -> bit 3.
  assign s_sel = {cin, ~cin, ~cin, cin};
  assign c_sel = {1'b1, cin, cin, 1'b0};

  assign s = s_sel[{x, y}];
  assign c = c_sel[{x, y}];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: latches operands on start, adds one bit per cycle LSB first,
// pulses done for one cycle after WIDTH shifts.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  serial_fa_cell u_fa (
    .x   (areg[0]),
    .y   (breg[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so bit i settles in sum[i] after WIDTH shifts.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          areg  <= {1'b0, areg[WIDTH-1:1]};
          breg  <= {1'b0, breg[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (last_bit) cout <= fa_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus randomized operands at
// WIDTH=8 and an exhaustive sweep at WIDTH=4, checked against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int unsigned W8 = WIDTH_DEFAULT;
  localparam int unsigned W4 = 4;

  logic          clk = 1'b0;
  logic          reset8, start8, cin8;
  logic [W8-1:0] a8, b8;
  logic          busy8, done8, cout8;
  logic [W8-1:0] sum8;
  logic          reset4, start4, cin4;
  logic [W4-1:0] a4, b4;
  logic          busy4, done4, cout4;
  logic [W4-1:0] sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle with the given operands, scrambles the operand inputs
  // afterwards, and observes the whole operation window.
  task automatic do_op(input logic [W8-1:0] ia, input logic [W8-1:0] ib, input logic ic,
                       output int lat, output int busy_n, output int done_n);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
    lat = -1; busy_n = 0; done_n = 0;
    for (int n = 0; n < int'(W8) + 4; n++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (lat < 0) lat = n;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset8 = 1'b1; reset4 = 1'b1; start8 = 1'b1; start4 = 1'b1;
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick(); tick();
    reset8 = 1'b0; reset4 = 1'b0; start8 = 1'b0; start4 = 1'b0;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b cout=%b sum=%h, expected all 0", busy4, done4, cout4, sum4);
    end
  endtask

  task automatic test_basic();
    int lat, bn, dn;
    do_op(8'h0F, 8'h01, 1'b0, lat, bn, dn);
    checks++;
    if (lat != int'(W8)) begin
      errors++;
      $display("FAIL basic_latency: got %0d, expected %0d", lat, W8);
    end
    checks++;
    if ({cout8, sum8} !== 9'h010) begin
      errors++;
      $display("FAIL basic_result: got cout=%b sum=%h, expected cout=0 sum=10", cout8, sum8);
    end
    start8 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({cout8, sum8} !== 9'h010) begin
      errors++;
      $display("FAIL basic_hold: got cout=%b sum=%h, expected cout=0 sum=10", cout8, sum8);
    end
  endtask

  task automatic test_overflow();
    int lat, bn, dn;
    do_op(8'hFF, 8'h01, 1'b0, lat, bn, dn);
    checks++;
    if ({cout8, sum8} !== 9'h100) begin
      errors++;
      $display("FAIL overflow_result: got cout=%b sum=%h, expected cout=1 sum=00", cout8, sum8);
    end
    checks++;
    if (bn != int'(W8) + 1) begin
      errors++;
      $display("FAIL overflow_busy_cycles: got %0d, expected %0d", bn, W8 + 1);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL overflow_done_count: got %0d, expected 1", dn);
    end
  endtask

  task automatic test_start_held();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    for (int n = 0; n < int'(W8); n++) tick();
    checks++;
    if (done8 !== 1'b1 || {cout8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL held_first_done: got done=%b cout=%b sum=%h, expected done=1 cout=1 sum=ff", done8, cout8, sum8);
    end
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL held_idle_gap: got busy=%b done=%b cout=%b sum=%h, expected busy=0 done=0 cout=1 sum=ff", busy8, done8, cout8, sum8);
    end
    tick();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || sum8 !== 8'h00) begin
      errors++;
      $display("FAIL held_reaccept: got busy=%b sum=%h, expected busy=1 sum=00", busy8, sum8);
    end
    for (int n = 0; n < int'(W8); n++) tick();
    checks++;
    if (done8 !== 1'b1 || {cout8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL held_second_done: got done=%b cout=%b sum=%h, expected done=1 cout=1 sum=ff", done8, cout8, sum8);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int dn = 0;
    int lat = -1;
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    for (int n = 0; n < int'(W8) + 6; n++) begin
      start8 = (n == 2);
      if (done8) begin
        dn++;
        if (lat < 0) lat = n;
      end
      tick();
    end
    start8 = 1'b0;
    checks++;
    if (dn != 1 || lat != int'(W8)) begin
      errors++;
      $display("FAIL ignore_done: got count=%0d at %0d, expected count=1 at %0d", dn, lat, W8);
    end
    checks++;
    if ({cout8, sum8} !== 9'h0FF || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got busy=%b cout=%b sum=%h, expected busy=0 cout=0 sum=ff", busy8, cout8, sum8);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, dn;
    int stray = 0;
    a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
    end
    for (int n = 0; n < int'(W8) + 3; n++) begin
      if (done8 || busy8) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d active cycles, expected 0", stray);
    end
    do_op(8'h03, 8'h04, 1'b0, lat, bn, dn);
    checks++;
    if ({cout8, sum8} !== 9'h007 || lat != int'(W8)) begin
      errors++;
      $display("FAIL midreset_after: got cout=%b sum=%h lat=%0d, expected cout=0 sum=07 lat=%0d", cout8, sum8, lat, W8);
    end
  endtask

  task automatic test_random();
    int lat, bn, dn;
    logic [W8-1:0] ra, rb;
    logic rc;
    int unsigned expv;
    for (int i = 0; i < 40; i++) begin
      ra = W8'($urandom); rb = W8'($urandom); rc = 1'($urandom);
      expv = int'(ra) + int'(rb) + int'(rc);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      do_op(ra, rb, rc, lat, bn, dn);
      checks++;
      if ({cout8, sum8} !== 9'(expv) || lat != int'(W8) || bn != int'(W8) + 1 || dn != 1) begin
        errors++;
        $display("FAIL random_%0d: %h+%h+%b got cout=%b sum=%h lat=%0d busy=%0d done=%0d, expected %h lat=%0d busy=%0d done=1",
                 i, ra, rb, rc, cout8, sum8, lat, bn, dn, 9'(expv), W8, W8 + 1);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    int unsigned expv;
    for (int unsigned x = 0; x < 16; x++) begin
      for (int unsigned y = 0; y < 16; y++) begin
        for (int unsigned c = 0; c < 2; c++) begin
          a4 = W4'(x); b4 = W4'(y); cin4 = 1'(c); start4 = 1'b1;
          tick();
          start4 = 1'b0; a4 = W4'($urandom); b4 = W4'($urandom);
          for (int n = 0; n < int'(W4); n++) tick();
          expv = x + y + c;
          checks++;
          if (done4 !== 1'b1 || {cout4, sum4} !== 5'(expv)) begin
            errors++;
            $display("FAIL exh4_%0d_%0d_%0d: got done=%b cout=%b sum=%h, expected done=1 value=%h",
                     x, y, c, done4, cout4, sum4, 5'(expv));
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_held();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_exhaustive_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an addition is in progress (states SHIFT and DONE).
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the result register.
REQ-011 The block SHALL have port cout, output, 1 bit, the final carry-out register.

Function
REQ-012 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted; on that edge the block SHALL latch a and b into operand shift registers, load the carry register with cin, clear the bit counter to 0, clear sum, and go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL push the LSBs of the A/B shift registers and the carry register through one full-adder cell.
REQ-015 On each SHIFT edge, the sum bit SHALL shift into sum at the MSB, so that after WIDTH shifts bit i lands in sum[i].
REQ-016 On each SHIFT edge, the carry register SHALL take the cell's carry, both operand registers SHALL shift right by one, and the counter SHALL increment.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the edge where the counter equals WIDTH-1, the block SHALL go to DONE and cout SHALL take the final carry.
REQ-018 DONE SHALL last one cycle with done=1, then the block SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: with start accepted at edge T, done SHALL be high in the cycle following edge T+WIDTH.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing, no change to latched operands.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 sum and cout SHALL hold their values from DONE until the next accepted start clears sum.
REQ-023 Arithmetic SHALL be unsigned: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-024 The counter width SHALL be clog2(WIDTH)+1 bits, with no wrap before WIDTH-1 is reached.

Reset
REQ-025 When reset=1 at an edge, the state SHALL become IDLE, and busy, done, cout, sum, the carry register, the counter and the operand registers SHALL all become 0.
REQ-026 Reset SHALL take priority over start at the same edge.
REQ-027 Reset asserted mid-operation SHALL abort the addition with no done pulse.
REQ-028 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-029 The FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the WIDTH default SHALL live in a shared constants file included by the block and its bench.
REQ-030 The 1-bit adder SHALL be a separate sub-module, serial_fa_cell (inputs x, y, cin; outputs s, c), built from two 4:1 muxes selected by {x,y}.
REQ-031 serial_fa_cell SHALL be instantiated exactly once, combinationally, inside serial_add_ctrl.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, a=0x0F, b=0x01, cin=0, start pulsed 1 cycle -> done high in the 9th cycle after the accepting edge, sum=0x10, cout=0.
REQ-033 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; busy high for exactly 9 cycles.
REQ-034 The bench SHALL cover: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then start held high continuously -> a new operation accepted only on the IDLE cycle after DONE.
REQ-035 The bench SHALL cover: a=0x55, b=0xAA, cin=0 accepted, then a/b changed to 0x00 and start pulsed during SHIFT -> sum=0xFF, cout=0, one done only.
REQ-036 The bench SHALL cover: reset asserted for 1 cycle at the 4th SHIFT cycle -> next cycle state IDLE, busy=0, sum=0, cout=0, no done pulse; a following a=0x03, b=0x04 -> sum=0x07.
REQ-037 The bench SHALL run an exhaustive self-check of all a, b, cin combinations at WIDTH=4 against a + b + cin.
